// File: rtl/tdc_hit_controller.sv
// tdc_hit_controller
// Sequences one TDC channel built on a MUX-chain delay line. The hit is gated
// into the line only while the channel is armed. The thermometer taps and the
// coarse counter are sampled together on every clock. A hit is seen when tap 0
// is set. The fine time is the popcount of the captured taps, and it is
// presented with the coarse time on a valid/ready handshake. After each
// accepted timestamp the channel stays disarmed for a dead time and until the
// line has drained. Hits that arrive while disarmed are counted.
//
// Ports:
//   clk          system clock, all state on the rising edge
//   rst_n        synchronous reset, active low
//   enable       channel enable; low disarms the channel and clears the coarse counter
//   hit_in       raw asynchronous hit
//   filtered_hit hit_in gated by arm; drives the delay-line input
//   taps         delay-line thermometer outputs
//   ts_valid     timestamp valid
//   ts_ready     consumer ready
//   ts_coarse    coarse time of the hit
//   ts_fine      number of ones in the captured taps
//   ts_sat       captured taps all ones (hit older than the line)
//   busy         channel is neither idle nor armed
//   missed_cnt   saturating count of hits rejected while disarmed
module tdc_hit_controller #(
  parameter int NTAPS       = 64,
  parameter int FINE_W      = 7,
  parameter int COARSE_W    = 16,
  parameter int DEAD_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                hit_in,
  output logic                filtered_hit,
  input  logic [NTAPS-1:0]    taps,
  output logic                ts_valid,
  input  logic                ts_ready,
  output logic [COARSE_W-1:0] ts_coarse,
  output logic [FINE_W-1:0]   ts_fine,
  output logic                ts_sat,
  output logic                busy,
  output logic [7:0]          missed_cnt
);

  localparam int DEAD_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARMED  = 3'd1,
    ST_ENCODE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DEAD   = 3'd4
  } state_t;

  state_t                state_r;
  logic [COARSE_W-1:0]   coarse_cnt_r;
  logic [NTAPS-1:0]      taps_q_r;
  logic [COARSE_W-1:0]   coarse_q_r;
  logic [NTAPS-1:0]      snap_r;
  logic [COARSE_W-1:0]   coarse_snap_r;
  logic [DEAD_W-1:0]     dead_cnt_r;
  logic                  ts_valid_r;
  logic [COARSE_W-1:0]   ts_coarse_r;
  logic [FINE_W-1:0]     ts_fine_r;
  logic                  ts_sat_r;
  logic [7:0]            missed_cnt_r;
  logic                  hit_sync1_r;
  logic                  hit_sync2_r;
  logic                  hit_sync_d_r;
  logic                  hit_rise_s;

  // Fine code: plain count of ones, so bubbles in the thermometer are not corrected.
  function automatic logic [FINE_W-1:0] popcount(input logic [NTAPS-1:0] v);
    logic [FINE_W-1:0] c;
    c = '0;
    for (int i = 0; i < NTAPS; i++) begin
      c = c + {{(FINE_W-1){1'b0}}, v[i]};
    end
    return c;
  endfunction

  // The only combinational path: the raw hit is gated straight into the line.
  assign filtered_hit = hit_in & (state_r == ST_ARMED);
  assign busy         = (state_r != ST_IDLE) && (state_r != ST_ARMED);
  assign ts_valid     = ts_valid_r;
  assign ts_coarse    = ts_coarse_r;
  assign ts_fine      = ts_fine_r;
  assign ts_sat       = ts_sat_r;
  assign missed_cnt   = missed_cnt_r;
  assign hit_rise_s   = hit_sync2_r & ~hit_sync_d_r;

  // Free-running coarse counter, held at zero while the channel is disabled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      coarse_cnt_r <= '0;
    end else if (enable) begin
      coarse_cnt_r <= coarse_cnt_r + COARSE_W'(1);
    end else begin
      coarse_cnt_r <= '0;
    end
  end

  // Taps and coarse time are sampled at the same edge, so they stay paired.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      taps_q_r   <= '0;
      coarse_q_r <= '0;
    end else begin
      taps_q_r   <= taps;
      coarse_q_r <= coarse_cnt_r;
    end
  end

  // Hit synchroniser and saturating count of rising hits seen while disarmed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_sync1_r  <= 1'b0;
      hit_sync2_r  <= 1'b0;
      hit_sync_d_r <= 1'b0;
      missed_cnt_r <= 8'd0;
    end else begin
      hit_sync1_r  <= hit_in;
      hit_sync2_r  <= hit_sync1_r;
      hit_sync_d_r <= hit_sync2_r;
      if (hit_rise_s && enable && (state_r != ST_ARMED) && (missed_cnt_r != 8'hFF)) begin
        missed_cnt_r <= missed_cnt_r + 8'd1;
      end
    end
  end

  // Channel sequencer: arm, capture, encode, handshake, dead time.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      snap_r        <= '0;
      coarse_snap_r <= '0;
      dead_cnt_r    <= '0;
      ts_valid_r    <= 1'b0;
      ts_coarse_r   <= '0;
      ts_fine_r     <= '0;
      ts_sat_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (enable) begin
            state_r <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (!enable) begin
            state_r <= ST_IDLE;
          end else if (taps_q_r[0]) begin
            snap_r        <= taps_q_r;
            coarse_snap_r <= coarse_q_r;
            state_r       <= ST_ENCODE;
          end
        end
        ST_ENCODE: begin
          if (!enable) begin
            // The pending capture is discarded.
            state_r <= ST_IDLE;
          end else begin
            ts_fine_r   <= popcount(snap_r);
            ts_sat_r    <= &snap_r;
            ts_coarse_r <= coarse_snap_r;
            ts_valid_r  <= 1'b1;
            state_r     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          // Not aborted by enable; a delivered timestamp is never lost.
          if (ts_ready) begin
            ts_valid_r <= 1'b0;
            dead_cnt_r <= DEAD_LOAD;
            state_r    <= enable ? ST_DEAD : ST_IDLE;
          end
        end
        ST_DEAD: begin
          if (dead_cnt_r != '0) begin
            dead_cnt_r <= dead_cnt_r - DEAD_W'(1);
          end
          if (!enable) begin
            state_r <= ST_IDLE;
          end else if ((dead_cnt_r == '0) && (taps_q_r == '0)) begin
            // Re-arm only once the line has drained, so a stale front cannot retrigger.
            state_r <= ST_ARMED;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tdc_hit_controller.sv
module tb_tdc_hit_controller;

  localparam int NTAPS    = 64;
  localparam int FINE_W   = 7;
  localparam int COARSE_W = 16;
  localparam int DEAD     = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                enable = 1'b0;
  logic                hit_in = 1'b0;
  logic                ts_ready = 1'b0;
  logic [NTAPS-1:0]    taps = '0;
  logic                filtered_hit;
  logic                ts_valid;
  logic [COARSE_W-1:0] ts_coarse;
  logic [FINE_W-1:0]   ts_fine;
  logic                ts_sat;
  logic                busy;
  logic [7:0]          missed_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int mc = 0;   // expected coarse counter value
  int missed_exp = 0;

  tdc_hit_controller #(
    .NTAPS(NTAPS), .FINE_W(FINE_W), .COARSE_W(COARSE_W), .DEAD_CYCLES(DEAD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .hit_in(hit_in),
    .filtered_hit(filtered_hit), .taps(taps), .ts_valid(ts_valid),
    .ts_ready(ts_ready), .ts_coarse(ts_coarse), .ts_fine(ts_fine),
    .ts_sat(ts_sat), .busy(busy), .missed_cnt(missed_cnt)
  );

  always #5 clk = ~clk;

  // Coarse time: number of enabled edges since reset or last disabled edge.
  always @(posedge clk) begin
    if (!rst_n || !enable) mc <= 0;
    else mc <= (mc + 1) % (1 << COARSE_W);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [NTAPS-1:0] rand_pattern();
    logic [NTAPS-1:0] p;
    int n;
    n = $urandom_range(1, NTAPS);
    p = '1;
    if (n < NTAPS) p = (64'd1 << n) - 64'd1;
    if (n < NTAPS - 1 && $urandom_range(0, 3) == 0) p[$urandom_range(n + 1, NTAPS - 1)] = 1'b1;
    return p;
  endfunction

  // One full hit: capture, hold for d clocks, accept, then dead time/drain.
  task automatic do_hit(input logic [NTAPS-1:0] pat, input int d_in, input int k,
                        input bit early, input bit drop_hold);
    logic [COARSE_W-1:0] ec;
    int fine_e, r, d;
    bit sat_e;
    d = early ? 0 : d_in;
    chk("armed", 64'(filtered_hit), 64'd1);
    ts_ready = early;
    ec = COARSE_W'(mc);
    fine_e = $countones(pat);
    sat_e = (pat == '1);
    taps = pat;
    tick;  // E0
    chk("valid_e0", 64'(ts_valid), 64'd0);
    tick;  // E1
    chk("valid_e1", 64'(ts_valid), 64'd0);
    chk("busy_enc", 64'(busy), 64'd1);
    tick;  // E2
    chk("valid_e2", 64'(ts_valid), 64'd1);
    chk("coarse", 64'(ts_coarse), 64'(ec));
    chk("fine", 64'(ts_fine), 64'(fine_e));
    chk("sat", 64'(ts_sat), 64'(sat_e));
    chk("gate_off", 64'(filtered_hit), 64'd0);
    if (drop_hold) enable = 1'b0;
    for (int i = 0; i < d; i++) begin
      tick;
      chk("hold_valid", 64'(ts_valid), 64'd1);
      chk("hold_coarse", 64'(ts_coarse), 64'(ec));
      chk("hold_fine", 64'(ts_fine), 64'(fine_e));
    end
    ts_ready = 1'b1;
    tick;  // A
    chk("valid_drop", 64'(ts_valid), 64'd0);
    ts_ready = 1'b0;
    if (drop_hold) begin
      chk("idle_after_hold", 64'(busy), 64'd0);
      taps = '0;
      repeat (3) begin
        tick;
        chk("disabled_gate", 64'(filtered_hit), 64'd0);
      end
      enable = 1'b1;
      tick;
      chk("rearm_enable", 64'(filtered_hit), 64'd1);
    end else begin
      r = (k + 2 > DEAD) ? k + 2 : DEAD;
      for (int j = 0; j < r; j++) begin
        if (j == k) taps = '0;
        tick;
        chk("rearm", 64'(filtered_hit), 64'(j + 1 == r));
      end
    end
  endtask

  // Hit captured, then enable dropped before encode completes.
  task automatic do_abort(input logic [NTAPS-1:0] pat, input bit after_e1);
    chk("armed_abort", 64'(filtered_hit), 64'd1);
    taps = pat;
    tick;  // E0
    if (after_e1) tick;
    enable = 1'b0;
    tick;
    chk("abort_busy", 64'(busy), 64'd0);
    taps = '0;
    repeat (3) begin
      tick;
      chk("abort_valid", 64'(ts_valid), 64'd0);
      chk("abort_gate", 64'(filtered_hit), 64'd0);
    end
    enable = 1'b1;
    tick;
    chk("abort_rearm", 64'(filtered_hit), 64'd1);
  endtask

  initial begin
    int guard;
    int mode;
    hit_in = 1'b1;
    enable = 1'b1;
    rst_n = 1'b0;
    repeat (3) tick;
    chk("rst_valid", 64'(ts_valid), 64'd0);
    chk("rst_coarse", 64'(ts_coarse), 64'd0);
    chk("rst_fine", 64'(ts_fine), 64'd0);
    chk("rst_sat", 64'(ts_sat), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_missed", 64'(missed_cnt), 64'd0);
    chk("rst_gate", 64'(filtered_hit), 64'd0);
    rst_n = 1'b1;
    tick;
    chk("armed_after_rst", 64'(filtered_hit), 64'd1);
    hit_in = 1'b0;
    #1;
    chk("gate_follows_lo", 64'(filtered_hit), 64'd0);
    hit_in = 1'b1;
    #1;
    chk("gate_follows_hi", 64'(filtered_hit), 64'd1);

    guard = 0;
    while (mc != 100 && guard < 70000) begin
      tick;
      guard++;
    end
    chk("reach_coarse_100", 64'(mc), 64'd100);
    do_hit(64'h0000_0000_0000_07FF, 2, 2, 1'b0, 1'b0);
    do_hit('1, 10, 5, 1'b0, 1'b0);
    do_abort(64'h0000_0000_0000_00FF, 1'b1);
    do_hit(64'h0000_0000_0000_0001, 1, 0, 1'b1, 1'b0);
    do_hit(64'h0000_0000_0000_000F, 3, 0, 1'b0, 1'b1);

    for (int t = 0; t < 16; t++) begin
      mode = $urandom_range(0, 9);
      if (mode == 0) begin
        do_abort(rand_pattern(), 1'($urandom_range(0, 1)));
      end else if (mode == 1) begin
        do_hit(rand_pattern(), $urandom_range(0, 4), 0, 1'b0, 1'b1);
      end else begin
        do_hit(rand_pattern(), $urandom_range(0, 4), $urandom_range(0, 6),
               1'($urandom_range(0, 1)), 1'b0);
      end
    end

    // Park a timestamp in HOLD, then pulse the hit while disarmed.
    taps = 64'h0000_0000_0000_003F;
    repeat (3) tick;
    chk("park_valid", 64'(ts_valid), 64'd1);
    hit_in = 1'b0;
    repeat (4) tick;
    chk("missed_zero", 64'(missed_cnt), 64'(missed_exp));
    for (int p = 0; p < 3; p++) begin
      hit_in = 1'b1; tick; tick;
      hit_in = 1'b0; tick; tick;
      missed_exp++;
    end
    repeat (4) tick;
    chk("missed_3", 64'(missed_cnt), 64'(missed_exp));
    for (int p = 0; p < 300; p++) begin
      hit_in = 1'b1; tick; tick;
      hit_in = 1'b0; tick; tick;
      if (missed_exp < 255) missed_exp++;
    end
    repeat (4) tick;
    chk("missed_sat", 64'(missed_cnt), 64'(missed_exp));
    chk("park_still_valid", 64'(ts_valid), 64'd1);

    // Reset while a timestamp is pending.
    rst_n = 1'b0;
    tick;
    chk("midrst_valid", 64'(ts_valid), 64'd0);
    chk("midrst_missed", 64'(missed_cnt), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_fine", 64'(ts_fine), 64'd0);
    rst_n = 1'b1;
    taps = '0;
    tick;
    hit_in = 1'b1;
    #1;
    chk("midrst_rearm", 64'(filtered_hit), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tdc_hit_controller.md
Name: tdc_hit_controller

Overview:
Sequences one FPGA TDC channel built on the MUX-chain delay line. It arms and gates the hit into the delay line and samples the line's thermometer taps each clock. It detects a hit, encodes the fine time by popcount, pairs it with a free-running coarse counter, and presents the timestamp on a valid/ready handshake. After each hit it enforces a dead time before re-arming, and counts hits lost while disarmed.

Parameters:
NTAPS, 64, number of delay-line taps (width of taps input)
FINE_W, 7, width of fine code; must satisfy 2**FINE_W > NTAPS
COARSE_W, 16, width of coarse counter / coarse timestamp
DEAD_CYCLES, 4, minimum disarmed clocks after each accepted timestamp (>=1)

Ports:
clk  in  1  system clock; all state on rising edge
rst_n  in  1  synchronous reset, active low
enable  in  1  channel enable; low forces disarm and clears coarse counter
hit_in  in  1  raw asynchronous hit
filtered_hit  out  1  hit_in AND arm; drives delay-line input
taps  in  NTAPS  delay-line Z outputs, thermometer code
ts_valid  out  1  timestamp valid
ts_ready  in  1  consumer ready
ts_coarse  out  COARSE_W  coarse time of hit
ts_fine  out  FINE_W  number of ones in captured taps
ts_sat  out  1  captured taps all ones (hit older than line length)
busy  out  1  state != IDLE && state != ARMED
missed_cnt  out  8  saturating count of hits rejected while disarmed

Behaviour:
- Reset (rst_n=0 at edge): state=IDLE; coarse_cnt, taps_q, coarse_q, dead_cnt, ts_* , missed_cnt, sync regs = 0; filtered_hit=0.
- coarse_cnt: +1 every clock while enable=1, wraps 2**COARSE_W-1 -> 0; held at 0 while enable=0.
- Every clock: taps_q <= taps; coarse_q <= coarse_cnt (pair sampled at the same edge).
- arm = (state==ARMED); filtered_hit = hit_in & arm (combinational; only combinational path).
- FSM:
  IDLE: arm=0; enable=1 -> ARMED.
  ARMED: taps_q[0]=1 -> ENCODE; latch snap<=taps_q, coarse_snap<=coarse_q.
  ENCODE: one cycle; ts_fine <= popcount(snap) (max NTAPS, no bubble correction), ts_sat <= (snap all ones), ts_coarse <= coarse_snap; -> HOLD.
  HOLD: ts_valid=1, outputs stable; ts_valid&ts_ready at edge -> DEAD, dead_cnt<=DEAD_CYCLES-1, ts_valid<=0.
  DEAD: arm=0; decrement dead_cnt; leave only when dead_cnt==0 AND taps_q==0 (line drained), extend otherwise; -> ARMED if enable else IDLE.
- Latency: taps_q[0] first seen 1 after edge E0 -> ENCODE after E1 -> ts_valid=1 after E2; ts_coarse = coarse_cnt value sampled at E0.
- enable=0: ARMED/ENCODE/DEAD -> IDLE next edge, pending capture discarded; HOLD is not aborted, stays until accepted, then -> IDLE.
- missed_cnt: hit_in 2-FF synchronised; rising edge of synced hit while enable=1 and state!=ARMED -> +1, saturates at 255; cleared only by reset.
- ts_ready ignored outside HOLD; ts_ready held high gives one-cycle HOLD.
- coarse wrap between E0 and output has no effect (value latched).
- Reset mid-operation: returns to IDLE next edge, any pending timestamp lost.

Test Plan:
1. Reset with enable=1 then deassert rst_n -> all outputs 0, state ARMED after 1 clk, filtered_hit follows hit_in.
2. Drive taps=0x00000000000007FF at edge where coarse_cnt=100 -> ts_valid 2 edges later, ts_coarse=100, ts_fine=11, ts_sat=0.
3. taps all ones (0xFFFFFFFFFFFFFFFF) -> ts_fine=64, ts_sat=1.
4. Hold ts_ready=0 for 10 clks -> ts_valid and ts_* stable; ready=1 -> valid drops next edge, filtered_hit=0 for >=4 clks, re-armed after taps=0; keep taps nonzero 3 extra clks -> re-arm delayed 3 clks.
5. Pulse hit_in 3 times during DEAD/HOLD -> missed_cnt=3; 300 pulses -> missed_cnt=255.
6. Drop enable in ARMED with hit mid-encode -> IDLE, no ts_valid, coarse_cnt=0; drop enable in HOLD -> timestamp still delivered, then IDLE.
